// File: rtl/sevenseg_scan_counter.sv
// N-digit BCD up/down counter with prescaler, parallel load and wrap flag, driving a
// time-multiplexed common-anode seven-segment display with optional leading-zero blanking.
module sevenseg_scan_counter #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            cath,
  output logic                  dp
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RcW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SelW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [RcW-1:0]  RcMax  = RcW'(REFRESH_DIV - 1);
  localparam logic [SelW-1:0] SelMax = SelW'(DIGITS - 1);

  logic [PreW-1:0]     pre_q, pre_d;
  logic [RcW-1:0]      rc_q, rc_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;

  // Out-of-range nibbles are forced to 0 so the counter never holds a non-BCD digit.
  function automatic logic [4*DIGITS-1:0] bcd_clean(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  // Ripple BCD increment (dir=1) or decrement (dir=0); MSB of result is the final carry/borrow.
  function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] v, input logic dir);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          nib;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = v[4*i +: 4];
      if (c) begin
        if (dir) begin
          if (nib == 4'd9) begin
            nib = 4'd0;
          end else begin
            nib = nib + 4'd1;
            c   = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            nib = 4'd9;
          end else begin
            nib = nib - 4'd1;
            c   = 1'b0;
          end
        end
      end
      r[4*i +: 4] = nib;
    end
    return {c, r};
  endfunction

  logic               step;
  logic [4*DIGITS:0]  stepped;

  assign step    = en && (pre_q == PreMax);
  assign stepped = bcd_step(count_q, up);

  // Count path: load beats step; load also restarts the prescaler phase.
  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = bcd_clean(load_val);
      pre_d   = '0;
    end else if (en) begin
      if (step) begin
        pre_d   = '0;
        count_d = stepped[4*DIGITS-1:0];
        wrap_d  = stepped[4*DIGITS];
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end
  end

  // Scan path free-runs independently of en/load.
  always_comb begin
    rc_d  = rc_q + RcW'(1);
    sel_d = sel_q;
    if (rc_q == RcMax) begin
      rc_d  = '0;
      sel_d = (sel_q == SelMax) ? '0 : sel_q + SelW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      rc_q    <= '0;
      sel_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      rc_q    <= rc_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  logic [3:0]        digit;
  logic [DIGITS-1:0] blank;
  logic              all_zero;
  logic              sel_blank;

  always_comb begin
    digit     = 4'd0;
    blank     = '0;
    all_zero  = 1'b1;
    sel_blank = 1'b0;
    // Walk from the most significant digit down; a digit blanks only under an all-zero prefix.
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero = all_zero && (count_q[4*i +: 4] == 4'd0);
      blank[i] = blank_lz && all_zero;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sel_q == SelW'(i)) begin
        digit     = count_q[4*i +: 4];
        sel_blank = blank[i];
      end
    end
  end

  always_comb begin
    an   = '1;
    cath = 7'b1111111;
    if (!sel_blank) begin
      an = ~(DIGITS'(1) << sel_q);
      case (digit)
        4'd0:    cath = 7'b1000000;
        4'd1:    cath = 7'b1111001;
        4'd2:    cath = 7'b0100100;
        4'd3:    cath = 7'b0110000;
        4'd4:    cath = 7'b0011001;
        4'd5:    cath = 7'b0010010;
        4'd6:    cath = 7'b0000010;
        4'd7:    cath = 7'b1111000;
        4'd8:    cath = 7'b0000000;
        4'd9:    cath = 7'b0010000;
        default: cath = 7'b1111111;
      endcase
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign dp    = 1'b1;

endmodule

// File: doc/sevenseg_scan_counter.md
# sevenseg_scan_counter

Parametrised multi-digit BCD up/down counter with a time-multiplexed, common-anode seven-segment scan driver. It generalises the two-digit free-running display counter to N digits and adds a rate prescaler, count direction, parallel load, wrap flag and leading-zero blanking. It sits between the board clock and the display pins on top-level demo designs; `count` is also exported for other logic.

## Interface
- `DIGITS`, default 4: number of BCD digits and anodes. Legal range 1..8.
- `TICK_DIV`, default 50_000_000: clk cycles per count step. Must be ≥1; 1 means step every enabled cycle.
- `REFRESH_DIV`, default 100_000: clk cycles each digit stays selected. Must be ≥1.
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: prescaler run enable.
- `up` in 1: 1 = count up, 0 = count down; sampled on the step cycle.
- `load` in 1: synchronous parallel load of `load_val`.
- `load_val` in 4*DIGITS: BCD value; digit i = bits [4i+3:4i].
- `blank_lz` in 1: 1 = blank leading zeros.
- `count` out 4*DIGITS: current BCD value, registered.
- `wrap` out 1: one-cycle pulse on a wrap step, registered.
- `an` out DIGITS: anode selects, active-low, one-hot-low.
- `cath` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, constant 1 (off).

## Operation
- Priority per cycle: `reset` > `load` > step > hold.
- Prescaler `pre` (width clog2(TICK_DIV), min 1):
  - Increments while `en`=1; holds while `en`=0.
  - A step fires in the cycle where `en`=1 and `pre`==TICK_DIV-1; `pre` then returns to 0.
- Load: `count` <= `load_val`, and `pre` <= 0. Any nibble >9 is stored as 0. `wrap` is 0 during a load cycle, even if a step would have fired.
- Step, up: ripple BCD increment. A digit at 9 becomes 0 and carries into the next digit. All-9s becomes all-0s and sets `wrap`=1 for exactly that one cycle.
- Step, down: ripple BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. All-0s becomes all-9s and sets `wrap`=1.
- Otherwise `wrap`=0.
- Scan:
  - Refresh counter `rc` free-runs regardless of `en` and `load`.
  - When `rc`==REFRESH_DIV-1, `rc` <= 0 and digit index `sel` advances 0,1,…,DIGITS-1,0.
  - With DIGITS=1, `sel` stays 0.
- Display outputs are combinational from registered `sel`, `count` and `blank_lz`:
  - `an` = all ones except bit `sel` = 0.
  - `cath` = decode of digit `sel`: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking: when `blank_lz`=1, digit i>0 is blanked if it and all higher digits are 0. A blanked digit drives `cath`=1111111 and leaves its `an` bit 1. Digit 0 is never blanked.
- Reset values: `count`=0, `pre`=0, `rc`=0, `sel`=0, `wrap`=0, `an`=~1 (digit 0 on), `cath`=1000000, `dp`=1.
- Reset mid-operation discards any pending step. Count and scan both restart from 0 on the first cycle after `reset` deasserts.

## Timing
- Step latency: `count` holds its new value from the edge following the cycle where `pre`==TICK_DIV-1 and `en`=1. `wrap` is high in the same cycle as that new value.
- Step period is exactly TICK_DIV enabled cycles. Deasserting `en` pauses the prescaler without loss of phase.
- Load latency: `count` = `load_val` from the next edge. The next step fires TICK_DIV enabled cycles later.
- Toggling `up` between steps takes effect at the next step only.
- `an`/`cath` follow `count` changes in the same cycle (no extra register).
- Scan: each digit is active for exactly REFRESH_DIV cycles. Full frame = DIGITS*REFRESH_DIV cycles.

## Test plan
Bench parameters: DIGITS=2, TICK_DIV=4, REFRESH_DIV=3.
- Reset, then `en`=1, `up`=1: `count` = 00,01,02… with one step every 4 cycles. 09→10 carries. After 99 → 00, `wrap` is high for exactly one cycle.
- `load_val`=8'h00, `up`=0, `en`=1: first step gives 99 with `wrap`=1. Then 98, then 97. Load 8'h10 then step down → 09.
- `load_val`=8'hA7: `count`=07. `load` and a step in the same cycle: `count`=load value, `wrap`=0, next step 4 enabled cycles later.
- `en` toggled 1/0 every cycle: step period stretches to 8 cycles. Scan continues, with `an` sequence 10,10,10,01,01,01.
- `count`=05, `blank_lz`=1: while `sel`=1, `an`=11 and `cath`=1111111. While `sel`=0, `an`=10 and `cath`=0010010. With `blank_lz`=0, `sel`=1 shows `cath`=1000000.
- Assert `reset` one cycle mid-count at 57 with `pre`=3: next cycle `count`=00, `wrap`=0, `sel`=0, and no step for 4 enabled cycles.
